wishbone_block_mem: RTL
=======================

Name: wishbone_block_mem

Overview:
- Wishbone secondary memory that sits at the far end of the cache's memory-side primary port.
- Serves block-wide (BLOCK_SIZE-bit) reads and byte-selectable writes, with a programmable number of wait states. This emulates DRAM/flash latency for cache refill and write-back traffic.
- Completes one transfer at a time and acknowledges each transfer with a single-cycle ack pulse.

Parameters:
- MEM_SIZE, 65536, memory capacity in bytes; must be a power of two.
- BLOCK_SIZE, 128, data bus width in bits; must be a power of two and at least 8.
- ADDR_SIZE, 32, width of the byte address.
- LATENCY, 4, cycles from request acceptance to ack; must be at least 1.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cyc  in  1  Wishbone cycle valid.
- stb  in  1  Wishbone strobe.
- we  in  1  1 = write, 0 = read.
- addr  in  ADDR_SIZE  byte address; low log2(BLOCK_SIZE/8) bits are ignored.
- sel  in  BLOCK_SIZE/8  byte enables, used for writes only.
- dat_i_s  in  BLOCK_SIZE  write data.
- dat_o_s  out  BLOCK_SIZE  read data, registered.
- ack  out  1  transfer complete; one-cycle pulse.
- err  out  1  bus error; one-cycle pulse (see Optional Feature).

Behaviour:
- Reset values: state IDLE; ack=0, err=0, dat_o_s=0; wait counter=0. Memory array contents are not cleared by reset.
- Word index: addr[log2(MEM_SIZE)-1 : log2(BLOCK_SIZE/8)]. Address bits above log2(MEM_SIZE) wrap (alias) unless BUS_ERR_EN is defined.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - When cyc&stb=1, latch addr, we, sel and dat_i_s.
  - Load counter with LATENCY-1.
  - Go to RESP if LATENCY=1, otherwise go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to RESP next cycle.
  - If cyc=0 in any WAIT cycle, abort: go to IDLE, perform no write, produce no ack.
- RESP (exactly one cycle):
  - ack=1.
  - Write: commit the latched data to the latched index, only for bytes whose latched sel bit is 1.
  - Read: dat_o_s shows the array word at the latched index in this same cycle, registered on entry to RESP.
  - Next state is always IDLE.
- Latency: ack is asserted exactly LATENCY cycles after the accepting edge.
  - Example: request seen at edge N means ack is high during the cycle after edge N+LATENCY-1.
- Handshake: the primary drops stb in the cycle after ack. If cyc&stb is still high in IDLE after RESP, it is a new request and is accepted.
- Input changes while in WAIT are ignored, because all request fields are latched.
- dat_o_s holds its last read value during writes and while idle.
- Read data reflects all writes whose ack has already occurred.
- Reset asserted in any state forces IDLE with no ack. An in-flight write is dropped and does not modify the array.

Optional Feature:
- Macro: WISHBONE_BLOCK_MEM_BUS_ERR_EN.
- Defined: a request whose addr is at or above MEM_SIZE follows the same timing, but asserts err instead of ack in RESP. No array write is performed, and dat_o_s is unchanged.
- Undefined: err is tied to 0 and out-of-range addresses alias modulo MEM_SIZE.

Decomposition:
- Package wishbone_block_mem_pkg:
  - state enum mem_state_t {IDLE, WAIT, RESP};
  - function index_width(MEM_SIZE, BLOCK_SIZE).
- Sub-module block_ram_array:
  - single-port synchronous RAM, depth MEM_SIZE*8/BLOCK_SIZE, width BLOCK_SIZE;
  - per-byte write enable and registered read.
- The top module holds the FSM, counter, request latches and error check.

Test Plan:
- Reset, then read at addr 0x0 with LATENCY=4 -> ack exactly 4 cycles after acceptance; dat_o_s=0 on power-up init (bench preloads 0); err=0.
- Write 128'hDEAD..BEEF to 0x40 with sel=16'hFFFF, then read 0x40 -> read returns DEAD..BEEF. Repeat the read at 0x4C -> same word, because the low 4 bits are ignored.
- Write 128'h0 to 0x40 with sel=16'h000F, then read 0x40 -> only bytes 0-3 are zero; bytes 4-15 keep the old value.
- Start a write to 0x80, drop cyc in cycle 2 of WAIT, then read 0x80 -> no ack for the aborted write; the old data is returned.
- Assert reset during WAIT of a write to 0xC0 -> ack stays 0; state is IDLE the next cycle; a subsequent read of 0xC0 returns the pre-write data.
- With BUS_ERR_EN defined, read 0x10000 (MEM_SIZE=65536) -> err pulses after LATENCY cycles, ack stays 0. With the macro undefined, the same access returns the word at 0x0 with ack.

Source files
------------

// File: rtl/wishbone_block_mem_pkg.sv
// Shared types and helpers for the Wishbone block memory.
//   mem_state_t  - request FSM states (IDLE, WAIT, RESP)
//   index_width  - number of word-index bits for a given capacity/width
package wishbone_block_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // Word-index width: log2 of the number of BLOCK_SIZE-bit words in MEM_SIZE bytes.
  function automatic int index_width(input int mem_size, input int block_size);
    return $clog2((mem_size * 8) / block_size);
  endfunction

endpackage

// File: rtl/wishbone_block_mem_block_ram_array.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
// Ports:
//   i_clk    - clock, rising edge
//   i_rst    - synchronous active-high reset; clears only the read register
//   i_re     - read enable; loads o_rdata from the addressed word
//   i_be     - per-byte write enables
//   i_idx    - word index (shared by read and write)
//   i_wdata  - write data
//   o_rdata  - registered read data, held while i_re is low
module block_ram_array #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 128,
  parameter int IDX_W = 12
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_re,
  input  logic [WIDTH/8-1:0] i_be,
  input  logic [IDX_W-1:0]   i_idx,
  input  logic [WIDTH-1:0]   i_wdata,
  output logic [WIDTH-1:0]   o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Array contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < WIDTH / 8; b++) begin
      if (i_be[b]) r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/wishbone_block_mem.sv
// Wishbone secondary memory serving block-wide reads and byte-selectable writes
// with LATENCY cycles from request acceptance to a single-cycle ack pulse.
// Optional feature macro: WISHBONE_BLOCK_MEM_BUS_ERR_EN -- when defined, requests
// at or above MEM_SIZE answer with err instead of ack and do not touch the array;
// when undefined, err is 0 and such addresses alias modulo MEM_SIZE.
// Ports:
//   clock, reset      - clock and synchronous active-high reset
//   cyc, stb, we      - Wishbone cycle, strobe, write select
//   addr              - byte address (low log2(BLOCK_SIZE/8) bits ignored)
//   sel, dat_i_s      - write byte enables and write data
//   dat_o_s           - registered read data
//   ack, err          - single-cycle completion / error pulses
//   dbg_state         - current FSM state for observation
// Handshake: a request is accepted on the edge where the FSM is IDLE and cyc&stb
// are high; all request fields are latched there. The transfer completes with a
// one-cycle ack (or err) exactly LATENCY cycles later. Dropping cyc while waiting
// abandons the transfer with no write and no ack.
module wishbone_block_mem
  import wishbone_block_mem_pkg::*;
#(
  parameter int MEM_SIZE   = 65536,
  parameter int BLOCK_SIZE = 128,
  parameter int ADDR_SIZE  = 32,
  parameter int LATENCY    = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cyc,
  input  logic                    stb,
  input  logic                    we,
  input  logic [ADDR_SIZE-1:0]    addr,
  input  logic [BLOCK_SIZE/8-1:0] sel,
  input  logic [BLOCK_SIZE-1:0]   dat_i_s,
  output logic [BLOCK_SIZE-1:0]   dat_o_s,
  output logic                    ack,
  output logic                    err,
  output mem_state_t              dbg_state
);

  localparam int MEM_AW   = $clog2(MEM_SIZE);
  localparam int BYTE_AW  = $clog2(BLOCK_SIZE / 8);
  localparam int IDX_W    = index_width(MEM_SIZE, BLOCK_SIZE);
  localparam int DEPTH    = (MEM_SIZE * 8) / BLOCK_SIZE;
  localparam int CNT_W    = (LATENCY < 2) ? 1 : $clog2(LATENCY);
  localparam bit SINGLE   = (LATENCY == 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mem_state_t              r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_ack;
  logic                    r_err;
  logic                    r_we;
  logic                    r_oor;
  logic [IDX_W-1:0]        r_idx;
  logic [BLOCK_SIZE/8-1:0] r_sel;
  logic [BLOCK_SIZE-1:0]   r_dat;

  logic                    w_accept;
  logic                    w_oor;
  logic                    w_last_wait;
  logic                    w_re;
  logic [BLOCK_SIZE/8-1:0] w_be;
  logic [IDX_W-1:0]        w_idx_in;
  logic [IDX_W-1:0]        w_ram_idx;
  logic                    w_unused;

  assign w_idx_in = addr[MEM_AW-1:BYTE_AW];
  // Ignored low byte-offset bits and (when aliasing) high bits are folded here.
  assign w_unused = ^addr;

`ifdef WISHBONE_BLOCK_MEM_BUS_ERR_EN
  assign w_oor = |(addr >> MEM_AW);
`else
  assign w_oor = 1'b0;
`endif

  assign w_accept    = (r_state == IDLE) && cyc && stb;
  assign w_last_wait = (r_state == WAIT) && cyc && (r_cnt == CNT_ONE);

  // The read is launched on the edge that enters RESP so dat_o_s is valid
  // together with ack. For LATENCY=1 that edge is the accepting edge, so the
  // unlatched request index is used while IDLE.
  assign w_ram_idx = (r_state == IDLE) ? w_idx_in : r_idx;
  assign w_re = !reset &&
                ((SINGLE && w_accept && !we && !w_oor) ||
                 (w_last_wait && !r_we && !r_oor));

  // Writes commit at the end of RESP; a reset in that cycle drops them.
  assign w_be = (!reset && (r_state == RESP) && r_we && !r_oor) ? r_sel : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_oor   <= 1'b0;
      r_idx   <= '0;
      r_sel   <= '0;
      r_dat   <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we  <= we;
            r_oor <= w_oor;
            r_idx <= w_idx_in;
            r_sel <= sel;
            r_dat <= dat_i_s;
            r_cnt <= CNT_INIT;
            if (SINGLE) begin
              r_state <= RESP;
              r_ack   <= !w_oor;
              r_err   <= w_oor;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!cyc) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_ONE) begin
            r_state <= RESP;
            r_cnt   <= r_cnt - CNT_ONE;
            r_ack   <= !r_oor;
            r_err   <= r_oor;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  block_ram_array #(
    .DEPTH (DEPTH),
    .WIDTH (BLOCK_SIZE),
    .IDX_W (IDX_W)
  ) u_ram (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_re    (w_re),
    .i_be    (w_be),
    .i_idx   (w_ram_idx),
    .i_wdata (r_dat),
    .o_rdata (dat_o_s)
  );

  assign ack       = r_ack;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule
